// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a saturating downstream-stall counter.
module pipe_stage_skid #(
  parameter int                  DATA_W    = 64,
  parameter logic [DATA_W-1:0]   RESET_VAL = {DATA_W{1'b0}},
  parameter int                  CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_xfer;
  logic              out_xfer;

  // Handshake outputs decode from state only, so out_ready never reaches in_ready.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != SKID);
  assign occupancy = state;
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state  <= MAIN;
            main_q <= in_data;
          end
        end
        MAIN: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (in_xfer) begin
            state  <= SKID;
            skid_q <= in_data;
          end else if (out_xfer) begin
            state  <= EMPTY;
            main_q <= RESET_VAL;
          end
        end
        SKID: begin
          // in_ready is low here, so only the drain path exists.
          if (out_xfer) begin
            state  <= MAIN;
            main_q <= skid_q;
            skid_q <= RESET_VAL;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= RESET_VAL;
          skid_q <= RESET_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (cnt_clr)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, skid, flush and
// stall-counter saturation with hand-computed expectations.
module tb_pipe_stage_skid;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic          cnt_clr;
  logic [CW-1:0] stall_cnt;

  int nchk = 0;
  int nerr = 0;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_occ",   64'(occupancy), 64'd0);
    chk("rst_cnt",   64'(stall_cnt), 64'd0);
    chk("rst_data",  out_data, 64'd0);
    #10 reset = 1'b1;
    step();

    // Streaming: 1 entry/cycle, occupancy stays 1.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = 64'(i);
      step();
      chk("strm_data", out_data, 64'(i));
      chk("strm_occ",  64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_drain_occ",  64'(occupancy), 64'd0);
    chk("strm_drain_data", out_data, 64'd0);
    chk("strm_cnt",        64'(stall_cnt), 64'd0);

    // Skid: A accepted, B into skid, C held off for the 3 stalled cycles.
    in_valid = 1'b1; in_data = 64'hA;
    step();
    chk("skid_a", out_data, 64'hA);
    out_ready = 1'b0; in_data = 64'hB;
    step();
    chk("skid_occ2",  64'(occupancy), 64'd2);
    chk("skid_rdy0",  64'(in_ready), 64'd0);
    in_data = 64'hC;
    step();
    step();
    chk("skid_cnt3",  64'(stall_cnt), 64'd3);
    chk("skid_hold",  out_data, 64'hA);
    chk("skid_occ2b", 64'(occupancy), 64'd2);
    out_ready = 1'b1;
    step();
    chk("skid_b",     out_data, 64'hB);
    chk("skid_occ1",  64'(occupancy), 64'd1);
    chk("skid_rdy1",  64'(in_ready), 64'd1);
    step();
    chk("skid_c",     out_data, 64'hC);
    in_valid = 1'b0;
    step();
    chk("skid_empty", 64'(occupancy), 64'd0);
    chk("skid_cnt_keep", 64'(stall_cnt), 64'd3);

    // Flush with occupancy 2 and a competing input.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_cnt", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1;
    step();
    in_data = 64'h2;
    step();
    chk("fl_occ2", 64'(occupancy), 64'd2);
    flush = 1'b1; in_data = 64'hDEAD;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_occ",   64'(occupancy), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_data",  out_data, 64'd0);
    chk("fl_rdy",   64'(in_ready), 64'd1);
    chk("fl_cnt",   64'(stall_cnt), 64'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_novalid", 64'(out_valid), 64'd0);
      chk("fl_nodead",  out_data, 64'd0);
    end

    // Counter saturation at 2^CW-1 and clear-over-increment.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55;
    step();
    in_valid = 1'b0;
    chk("cnt_start", 64'(stall_cnt), 64'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("cnt_14", 64'(stall_cnt), 64'd14);
    end
    chk("cnt_sat", 64'(stall_cnt), 64'd15);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("cnt_clr_win", 64'(stall_cnt), 64'd0);
    step();
    chk("cnt_resume", 64'(stall_cnt), 64'd1);

    // Asynchronous reset mid-stream with occupancy 2.
    in_valid = 1'b1; in_data = 64'h66;
    step();
    in_valid = 1'b0;
    chk("ar_occ2", 64'(occupancy), 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_data",  out_data, 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_occ",   64'(occupancy), 64'd0);
    chk("ar_cnt",   64'(stall_cnt), 64'd0);
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ar_idle", 64'(out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
